// File: rtl/block_memory_if.sv
// rtl/block_memory_if.sv - Block-transfer bus between the cache and its backing memory
interface block_memory_if #(
    parameter int ADDR_W  = 10,
    parameter int BLOCK_W = 128
);
    logic               ReadOrWrite;
    logic [ADDR_W-1:0]  Addr;
    logic [BLOCK_W-1:0] WriteData;
    logic [BLOCK_W-1:0] ReadData;

    // Cache side drives address/data, memory side returns the selected block.
    modport master (
        output ReadOrWrite,
        output Addr,
        output WriteData,
        input  ReadData
    );

    modport slave (
        input  ReadOrWrite,
        input  Addr,
        input  WriteData,
        output ReadData
    );
endinterface

// File: rtl/block_memory.sv
// rtl/block_memory.sv - 1 KiB block-organised main memory behind a write-through cache
module block_memory #(
    parameter int ADDR_W  = 10,
    parameter int BLOCK_W = 128
) (
    input  logic          clk,
    input  logic          rst_n,
    block_memory_if.slave bus
);
    localparam int NUM_BLOCKS      = 1 << (ADDR_W - 4);
    localparam int WORDS_PER_BLOCK = BLOCK_W / 32;

    logic [BLOCK_W-1:0]  mem [NUM_BLOCKS];
    logic [ADDR_W-5:0]   blockIdx;

    // Offset bits only pick a byte inside the block, so they never select storage.
    assign blockIdx = bus.Addr[ADDR_W-1:4];

    // Reset image: word w holds the value w, word 0 of a block in the top bits.
    function automatic logic [BLOCK_W-1:0] resetBlock(input int b);
        logic [BLOCK_W-1:0] blk;
        blk = '0;
        for (int w = 0; w < WORDS_PER_BLOCK; w++) begin
            blk[BLOCK_W-1-32*w -: 32] = 32'(WORDS_PER_BLOCK * b + w);
        end
        return blk;
    endfunction

    // Reset reloads the whole image and wins over a coincident write; otherwise whole-block writes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int b = 0; b < NUM_BLOCKS; b++) begin
                mem[b] <= resetBlock(b);
            end
        end else if (bus.ReadOrWrite) begin
            mem[blockIdx] <= bus.WriteData;
        end
    end

    // Unregistered read: the cache consumes the block in the same cycle it presents Addr.
    assign bus.ReadData = mem[blockIdx];
endmodule

// File: tb/tb_block_memory.sv
// tb/tb_block_memory.sv - Self-checking bench for block_memory against a word-array model
module tb_block_memory;
    localparam int ADDR_W  = 10;
    localparam int BLOCK_W = 128;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   passed = 0;

    // Reference memory kept as 256 plain 32-bit words, byte address / 4 = word index.
    logic [31:0] refWords [256];

    block_memory_if #(.ADDR_W(ADDR_W), .BLOCK_W(BLOCK_W)) bus ();

    block_memory #(.ADDR_W(ADDR_W), .BLOCK_W(BLOCK_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic void modelReset();
        for (int w = 0; w < 256; w++) refWords[w] = 32'(w);
    endfunction

    function automatic logic [BLOCK_W-1:0] modelRead(input logic [ADDR_W-1:0] a);
        int base;
        base = (int'(a) / 16) * 4;
        return {refWords[base], refWords[base+1], refWords[base+2], refWords[base+3]};
    endfunction

    function automatic void modelWrite(input logic [ADDR_W-1:0] a, input logic [BLOCK_W-1:0] d);
        int base;
        base = (int'(a) / 16) * 4;
        refWords[base]   = d[127:96];
        refWords[base+1] = d[95:64];
        refWords[base+2] = d[63:32];
        refWords[base+3] = d[31:0];
    endfunction

    // One rising edge; the model applies the memory's edge rule to the inputs that were presented.
    task automatic edgeStep();
        logic                 r;
        logic                 rw;
        logic [ADDR_W-1:0]    a;
        logic [BLOCK_W-1:0]   d;
        r  = rst_n;
        rw = bus.ReadOrWrite;
        a  = bus.Addr;
        d  = bus.WriteData;
        @(posedge clk);
        #1;
        if (!r) modelReset();
        else if (rw) modelWrite(a, d);
    endtask

    task automatic test_reset();
        logic [BLOCK_W-1:0] exp;
        rst_n = 1'b0;
        bus.ReadOrWrite = 1'b0;
        bus.Addr = '0;
        bus.WriteData = '0;
        edgeStep();
        rst_n = 1'b1;
        bus.Addr = 10'h000;
        #1;
        exp = 128'h00000000_00000001_00000002_00000003;
        checks++;
        if (bus.ReadData !== exp) $display("FAIL reset_blk0: got %h expected %h", bus.ReadData, exp);
        else passed++;
    endtask

    task automatic test_offset_ignored();
        logic [BLOCK_W-1:0] exp;
        exp = 128'h00000004_00000005_00000006_00000007;
        bus.ReadOrWrite = 1'b0;
        bus.Addr = 10'h014;
        #1;
        checks++;
        if (bus.ReadData !== exp) $display("FAIL offset_014: got %h expected %h", bus.ReadData, exp);
        else passed++;
        bus.Addr = 10'h01F;
        #1;
        checks++;
        if (bus.ReadData !== exp) $display("FAIL offset_01F: got %h expected %h", bus.ReadData, exp);
        else passed++;
    endtask

    task automatic test_write_top();
        logic [BLOCK_W-1:0] exp;
        bus.ReadOrWrite = 1'b1;
        bus.Addr = 10'h3FC;
        bus.WriteData = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
        edgeStep();
        bus.ReadOrWrite = 1'b0;
        bus.Addr = 10'h3F0;
        #1;
        exp = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
        checks++;
        if (bus.ReadData !== exp) $display("FAIL write_top: got %h expected %h", bus.ReadData, exp);
        else passed++;
        bus.Addr = 10'h3E0;
        #1;
        exp = 128'h000000F8_000000F9_000000FA_000000FB;
        checks++;
        if (bus.ReadData !== exp) $display("FAIL neighbour_3E0: got %h expected %h", bus.ReadData, exp);
        else passed++;
    endtask

    task automatic test_read_during_write();
        logic [BLOCK_W-1:0] oldBlk;
        logic [BLOCK_W-1:0] newBlk;
        oldBlk = 128'h0000003C_0000003D_0000003E_0000003F;
        newBlk = 128'h11112222_33334444_55556666_77778888;
        bus.ReadOrWrite = 1'b1;
        bus.Addr = 10'h0F7;
        bus.WriteData = newBlk;
        #1;
        checks++;
        if (bus.ReadData !== oldBlk) $display("FAIL rdw_before: got %h expected %h", bus.ReadData, oldBlk);
        else passed++;
        edgeStep();
        checks++;
        if (bus.ReadData !== newBlk) $display("FAIL rdw_after: got %h expected %h", bus.ReadData, newBlk);
        else passed++;
        bus.ReadOrWrite = 1'b0;
        bus.WriteData = '1;
        for (int i = 0; i < 3; i++) edgeStep();
        checks++;
        if (bus.ReadData !== newBlk) $display("FAIL idle_hold: got %h expected %h", bus.ReadData, newBlk);
        else passed++;
    endtask

    task automatic test_reset_priority();
        logic [BLOCK_W-1:0] exp;
        bus.ReadOrWrite = 1'b1;
        bus.Addr = 10'h050;
        bus.WriteData = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
        edgeStep();
        checks++;
        if (bus.ReadData !== 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0)
            $display("FAIL blk5_written: got %h expected %h", bus.ReadData, 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0);
        else passed++;
        rst_n = 1'b0;
        bus.WriteData = '1;
        edgeStep();
        rst_n = 1'b1;
        bus.ReadOrWrite = 1'b0;
        #1;
        exp = 128'h00000014_00000015_00000016_00000017;
        checks++;
        if (bus.ReadData !== exp) $display("FAIL reset_priority: got %h expected %h", bus.ReadData, exp);
        else passed++;
        bus.Addr = 10'h0F0;
        #1;
        exp = 128'h0000003C_0000003D_0000003E_0000003F;
        checks++;
        if (bus.ReadData !== exp) $display("FAIL reset_clears_prior: got %h expected %h", bus.ReadData, exp);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [BLOCK_W-1:0] d2;
        logic [BLOCK_W-1:0] d3;
        logic [BLOCK_W-1:0] exp;
        d2 = 128'h22222222_AAAAAAAA_00000002_12345678;
        d3 = 128'h33333333_BBBBBBBB_00000003_87654321;
        bus.ReadOrWrite = 1'b1;
        bus.Addr = 10'h020;
        bus.WriteData = d2;
        edgeStep();
        bus.Addr = 10'h03A;
        bus.WriteData = d3;
        edgeStep();
        bus.ReadOrWrite = 1'b0;
        bus.Addr = 10'h02F;
        #1;
        checks++;
        if (bus.ReadData !== d2) $display("FAIL b2b_blk2: got %h expected %h", bus.ReadData, d2);
        else passed++;
        bus.Addr = 10'h030;
        #1;
        checks++;
        if (bus.ReadData !== d3) $display("FAIL b2b_blk3: got %h expected %h", bus.ReadData, d3);
        else passed++;
        bus.Addr = 10'h010;
        #1;
        exp = 128'h00000004_00000005_00000006_00000007;
        checks++;
        if (bus.ReadData !== exp) $display("FAIL b2b_blk1: got %h expected %h", bus.ReadData, exp);
        else passed++;
        bus.Addr = 10'h040;
        #1;
        exp = 128'h00000010_00000011_00000012_00000013;
        checks++;
        if (bus.ReadData !== exp) $display("FAIL b2b_blk4: got %h expected %h", bus.ReadData, exp);
        else passed++;
    endtask

    task automatic test_random();
        logic [BLOCK_W-1:0] exp;
        for (int i = 0; i < 300; i++) begin
            rst_n = ($urandom_range(0, 63) != 0);
            bus.ReadOrWrite = $urandom_range(0, 1) == 1;
            bus.Addr = 10'($urandom);
            bus.WriteData = {$urandom, $urandom, $urandom, $urandom};
            #1;
            exp = modelRead(bus.Addr);
            checks++;
            if (bus.ReadData !== exp)
                $display("FAIL rand_pre[%0d]: addr %h got %h expected %h", i, bus.Addr, bus.ReadData, exp);
            else passed++;
            edgeStep();
            exp = modelRead(bus.Addr);
            checks++;
            if (bus.ReadData !== exp)
                $display("FAIL rand_post[%0d]: addr %h got %h expected %h", i, bus.Addr, bus.ReadData, exp);
            else passed++;
            bus.Addr = 10'($urandom);
            #1;
            exp = modelRead(bus.Addr);
            checks++;
            if (bus.ReadData !== exp)
                $display("FAIL rand_other[%0d]: addr %h got %h expected %h", i, bus.Addr, bus.ReadData, exp);
            else passed++;
        end
        rst_n = 1'b1;
        bus.ReadOrWrite = 1'b0;
    endtask

    initial begin
        modelReset();
        rst_n = 1'b1;
        bus.ReadOrWrite = 1'b0;
        bus.Addr = '0;
        bus.WriteData = '0;
        #2;
        test_reset();
        test_offset_ignored();
        test_write_top();
        test_read_during_write();
        test_reset_priority();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
